// File: rtl/puf_challenge_sequencer_if.sv
// puf_challenge_sequencer_if
//   Bundles the challenge handshake, the PUF array drive/sense lines and the
//   voted-response handshake of the PUF challenge sequencer.
//   master : sequencer side (drives chal_ready, CHALLENGE, trigger, puf_reset,
//            resp_valid, resp_data, resp_unstable)
//   slave  : environment side (drives chal_valid, chal_data, RESPONSE,
//            resp_ready)
interface puf_challenge_sequencer_if;
  logic         chal_valid;
  logic         chal_ready;
  logic [127:0] chal_data;
  logic [127:0] CHALLENGE;
  logic         trigger;
  logic         puf_reset;
  logic [15:0]  RESPONSE;
  logic         resp_valid;
  logic         resp_ready;
  logic [15:0]  resp_data;
  logic [15:0]  resp_unstable;

  modport master (
    input  chal_valid, chal_data, RESPONSE, resp_ready,
    output chal_ready, CHALLENGE, trigger, puf_reset,
           resp_valid, resp_data, resp_unstable
  );

  modport slave (
    output chal_valid, chal_data, RESPONSE, resp_ready,
    input  chal_ready, CHALLENGE, trigger, puf_reset,
           resp_valid, resp_data, resp_unstable
  );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer
//   Accepts a 128-bit challenge, applies it to an arbiter PUF array and runs
//   NUM_EVAL evaluations (PUF reset, settle, trigger, capture). Each response
//   bit is majority-voted across the evaluations and flagged unstable when
//   the evaluations disagreed.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : puf_challenge_sequencer_if.master
//            chal_valid/chal_ready/chal_data  challenge handshake
//            CHALLENGE/trigger/puf_reset      PUF array drive
//            RESPONSE                         raw PUF array response
//            resp_valid/resp_ready            voted response handshake
//            resp_data/resp_unstable          voted response and disagreement
//
// state | meaning
// IDLE  | waiting for a challenge, chal_ready high
// PRST  | PUF arbiters held in reset for RST_CYCLES
// SETUP | reset released, arbiters settle for SETUP_CYCLES
// FIRE  | trigger high for EVAL_CYCLES
// CAPT  | trigger still high, RESPONSE added into the vote counters
// DONE  | voted response presented until consumed
module puf_challenge_sequencer #(
  parameter int RST_CYCLES   = 4,
  parameter int SETUP_CYCLES = 8,
  parameter int EVAL_CYCLES  = 16,
  parameter int NUM_EVAL     = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  puf_challenge_sequencer_if.master  bus
);

  localparam int MAX_RS  = (RST_CYCLES > SETUP_CYCLES) ? RST_CYCLES : SETUP_CYCLES;
  localparam int MAX_CYC = (MAX_RS > EVAL_CYCLES) ? MAX_RS : EVAL_CYCLES;
  localparam int TW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  // Timer loads are one less than the phase length: the phase ends on the
  // cycle the down-counter reaches zero.
  localparam logic [TW-1:0] RST_LOAD   = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] EVAL_LOAD  = TW'(EVAL_CYCLES - 1);
  localparam logic [3:0]    LAST_EVAL  = 4'(NUM_EVAL - 1);
  localparam logic [3:0]    HALF_EVAL  = 4'(NUM_EVAL / 2);
  localparam logic [3:0]    ALL_EVAL   = 4'(NUM_EVAL);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRST  = 3'd1,
    SETUP = 3'd2,
    FIRE  = 3'd3,
    CAPT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tmr;
  logic          tmr_done;
  logic [3:0]    eval_cnt;
  logic [3:0]    vote     [16];
  logic [3:0]    vote_upd [16];

  assign tmr_done = (tmr == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.chal_valid) state_nxt = PRST;
      PRST:    if (tmr_done) state_nxt = SETUP;
      SETUP:   if (tmr_done) state_nxt = FIRE;
      FIRE:    if (tmr_done) state_nxt = CAPT;
      CAPT:    state_nxt = (eval_cnt == LAST_EVAL) ? DONE : PRST;
      DONE:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counts including the current RESPONSE, so the verdict taken on the
  // final CAPT cycle already sees the last evaluation.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      vote_upd[i] = vote[i] + {3'b000, bus.RESPONSE[i]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr               <= '0;
      eval_cnt          <= '0;
      for (int i = 0; i < 16; i++) vote[i] <= '0;
      bus.chal_ready    <= 1'b1;
      bus.CHALLENGE     <= '0;
      bus.trigger       <= 1'b0;
      bus.puf_reset     <= 1'b0;
      bus.resp_valid    <= 1'b0;
      bus.resp_data     <= '0;
      bus.resp_unstable <= '0;
    end else begin
      if (state_nxt != state) begin
        case (state_nxt)
          PRST:    tmr <= RST_LOAD;
          SETUP:   tmr <= SETUP_LOAD;
          FIRE:    tmr <= EVAL_LOAD;
          default: tmr <= '0;
        endcase
      end else if (!tmr_done) begin
        tmr <= tmr - TW'(1);
      end

      if (state == IDLE && bus.chal_valid) begin
        bus.CHALLENGE <= bus.chal_data;
        eval_cnt      <= '0;
        for (int i = 0; i < 16; i++) vote[i] <= '0;
      end

      if (state == CAPT) begin
        eval_cnt <= eval_cnt + 4'd1;
        for (int i = 0; i < 16; i++) vote[i] <= vote_upd[i];
        if (state_nxt == DONE) begin
          for (int i = 0; i < 16; i++) begin
            bus.resp_data[i]     <= (vote_upd[i] > HALF_EVAL);
            bus.resp_unstable[i] <= (vote_upd[i] != 4'd0) && (vote_upd[i] < ALL_EVAL);
          end
        end
      end

      // Registered outputs follow the state being entered.
      bus.chal_ready <= (state_nxt == IDLE);
      bus.puf_reset  <= (state_nxt == PRST);
      bus.trigger    <= (state_nxt == FIRE) || (state_nxt == CAPT);
      bus.resp_valid <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
module tb_puf_challenge_sequencer;
  localparam int R   = 4;
  localparam int S   = 8;
  localparam int E   = 16;
  localparam int N   = 5;
  localparam int P   = R + S + E + 1;
  localparam int LAT = N * P;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  puf_challenge_sequencer_if bus ();
  puf_challenge_sequencer_if bus2 ();

  puf_challenge_sequencer #(.RST_CYCLES(R), .SETUP_CYCLES(S), .EVAL_CYCLES(E), .NUM_EVAL(N))
    dut (.clk(clk), .reset(reset), .bus(bus.master));

  puf_challenge_sequencer #(.RST_CYCLES(1), .SETUP_CYCLES(1), .EVAL_CYCLES(1), .NUM_EVAL(1))
    dut2 (.clk(clk), .reset(reset), .bus(bus2.master));

  int total = 0;
  int bad = 0;
  logic [15:0]  plan [N];
  logic [15:0]  exp_d, exp_u;
  logic [127:0] cur_chal;

  // Majority: strictly more than half of the evaluations saw a one.
  task automatic compute_expect();
    for (int i = 0; i < 16; i++) begin
      int ones;
      ones = 0;
      for (int e = 0; e < N; e++) ones += int'(plan[e][i]);
      exp_d[i] = (ones * 2 > N);
      exp_u[i] = (ones != 0) && (ones != N);
    end
  endtask

  task automatic do_challenge(input logic [127:0] chal, input bit noisy);
    int guard;
    @(negedge clk);
    bus.chal_data  = chal;
    bus.chal_valid = 1'b1;
    cur_chal       = chal;
    guard = 0;
    while (bus.chal_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 50) begin bad++; $display("FAIL accept_wait chal_ready=%b want=1", bus.chal_ready); end
    @(posedge clk);
    for (int c = 0; c < LAT; c++) begin
      int p, e;
      p = c % P;
      e = c / P;
      @(negedge clk);
      bus.chal_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.RESPONSE   = (p == P - 1 || !noisy) ? plan[e] : 16'($urandom());
      bus.resp_ready = (c < LAT - 1) ? 1'($urandom()) : 1'b0;
      total++;
      if (bus.puf_reset !== (p < R)) begin bad++; $display("FAIL wave_puf_reset c=%0d got=%b want=%b", c, bus.puf_reset, (p < R)); end
      total++;
      if (bus.trigger !== (p >= R + S)) begin bad++; $display("FAIL wave_trigger c=%0d got=%b want=%b", c, bus.trigger, (p >= R + S)); end
      total++;
      if (bus.chal_ready !== 1'b0) begin bad++; $display("FAIL busy_chal_ready c=%0d got=%b want=0", c, bus.chal_ready); end
      total++;
      if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL early_resp_valid c=%0d got=%b want=0", c, bus.resp_valid); end
      total++;
      if (bus.CHALLENGE !== chal) begin bad++; $display("FAIL challenge_hold c=%0d got=%h want=%h", c, bus.CHALLENGE, chal); end
      @(posedge clk);
    end
    @(negedge clk);
    compute_expect();
    total++;
    if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL latency_resp_valid got=%b want=1", bus.resp_valid); end
    total++;
    if (bus.resp_data !== exp_d) begin bad++; $display("FAIL resp_data got=%h want=%h", bus.resp_data, exp_d); end
    total++;
    if (bus.resp_unstable !== exp_u) begin bad++; $display("FAIL resp_unstable got=%h want=%h", bus.resp_unstable, exp_u); end
    total++;
    if (bus.trigger !== 1'b0 || bus.puf_reset !== 1'b0 || bus.chal_ready !== 1'b0) begin
      bad++; $display("FAIL done_outputs trig=%b prst=%b rdy=%b want=000", bus.trigger, bus.puf_reset, bus.chal_ready);
    end
    total++;
    if (bus.CHALLENGE !== chal) begin bad++; $display("FAIL done_challenge got=%h want=%h", bus.CHALLENGE, chal); end
  endtask

  task automatic release_resp();
    @(negedge clk);
    bus.chal_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.chal_ready !== 1'b1) begin
      bad++; $display("FAIL release valid=%b ready=%b want valid=0 ready=1", bus.resp_valid, bus.chal_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.CHALLENGE !== 128'd0 || bus.trigger !== 1'b0 || bus.puf_reset !== 1'b0 || bus.resp_valid !== 1'b0 ||
        bus.resp_data !== 16'd0 || bus.resp_unstable !== 16'd0) begin
      bad++; $display("FAIL reset_outputs chal=%h trig=%b prst=%b valid=%b data=%h unst=%h want all 0",
                      bus.CHALLENGE, bus.trigger, bus.puf_reset, bus.resp_valid, bus.resp_data, bus.resp_unstable);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.chal_ready !== 1'b1) begin bad++; $display("FAIL reset_chal_ready got=%b want=1", bus.chal_ready); end
    total++;
    if (bus2.chal_ready !== 1'b1 || bus2.resp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_dut2 ready=%b valid=%b want 1 0", bus2.chal_ready, bus2.resp_valid);
    end
  endtask

  task automatic test_fixed_response();
    for (int e = 0; e < N; e++) plan[e] = 16'hA5C3;
    do_challenge(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0);
    total++;
    if (bus.resp_data !== 16'hA5C3 || bus.resp_unstable !== 16'h0000) begin
      bad++; $display("FAIL fixed_vote data=%h unst=%h want a5c3 0000", bus.resp_data, bus.resp_unstable);
    end
    release_resp();
  endtask

  task automatic test_split_vote();
    for (int e = 0; e < N; e++) begin
      plan[e] = 16'($urandom());
      plan[e][0] = (e == 0 || e == 2 || e == 4);
      plan[e][1] = (e == 0 || e == 1);
    end
    do_challenge({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
    total++;
    if (bus.resp_data[1:0] !== 2'b01 || bus.resp_unstable[1:0] !== 2'b11) begin
      bad++; $display("FAIL split_vote data=%b unst=%b want 01 11", bus.resp_data[1:0], bus.resp_unstable[1:0]);
    end
    release_resp();
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      logic [15:0] base;
      base = 16'($urandom());
      for (int e = 0; e < N; e++) plan[e] = base ^ (16'($urandom()) & 16'($urandom()) & 16'($urandom()));
      do_challenge({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
      release_resp();
    end
  endtask

  task automatic test_back_to_back_hold();
    logic [127:0] first, second;
    for (int e = 0; e < N; e++) plan[e] = 16'($urandom());
    first  = {$urandom(), $urandom(), $urandom(), $urandom()};
    second = ~first;
    do_challenge(first, 1'b1);
    bus.chal_valid = 1'b1;
    bus.chal_data  = second;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== exp_d || bus.resp_unstable !== exp_u ||
          bus.chal_ready !== 1'b0 || bus.CHALLENGE !== first) begin
        bad++; $display("FAIL done_hold c=%0d valid=%b data=%h/%h unst=%h/%h rdy=%b", c, bus.resp_valid,
                        bus.resp_data, exp_d, bus.resp_unstable, exp_u, bus.chal_ready);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.chal_ready !== 1'b1 || bus.CHALLENGE !== first) begin
      bad++; $display("FAIL handshake_priority valid=%b rdy=%b chal=%h want 0 1 %h", bus.resp_valid, bus.chal_ready, bus.CHALLENGE, first);
    end
    @(posedge clk);
    @(negedge clk);
    bus.chal_valid = 1'b0;
    total++;
    if (bus.chal_ready !== 1'b0 || bus.puf_reset !== 1'b1 || bus.CHALLENGE !== second) begin
      bad++; $display("FAIL accept_after_done rdy=%b prst=%b chal=%h want 0 1 %h", bus.chal_ready, bus.puf_reset, bus.CHALLENGE, second);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus.chal_valid = 1'b1;
    bus.chal_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.RESPONSE   = 16'hFFFF;
    total++;
    if (bus.chal_ready !== 1'b1) begin bad++; $display("FAIL abort_start rdy=%b want=1", bus.chal_ready); end
    @(posedge clk);
    #1 bus.chal_valid = 1'b0;
    repeat (2 * P + R + S + 1) @(posedge clk);
    #2;
    total++;
    if (bus.trigger !== 1'b1) begin bad++; $display("FAIL abort_in_fire trig=%b want=1", bus.trigger); end
    reset = 1'b0;
    #1;
    total++;
    if (bus.CHALLENGE !== 128'd0 || bus.trigger !== 1'b0 || bus.puf_reset !== 1'b0 || bus.resp_valid !== 1'b0 ||
        bus.resp_data !== 16'd0 || bus.resp_unstable !== 16'd0 || bus.chal_ready !== 1'b1) begin
      bad++; $display("FAIL async_reset chal=%h trig=%b prst=%b valid=%b data=%h unst=%h rdy=%b", bus.CHALLENGE,
                      bus.trigger, bus.puf_reset, bus.resp_valid, bus.resp_data, bus.resp_unstable, bus.chal_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int e = 0; e < N; e++) plan[e] = 16'hFFFF;
    do_challenge({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
    total++;
    if (bus.resp_data !== 16'hFFFF || bus.resp_unstable !== 16'h0000) begin
      bad++; $display("FAIL post_abort data=%h unst=%h want ffff 0000", bus.resp_data, bus.resp_unstable);
    end
    release_resp();
  endtask

  task automatic test_min_config();
    for (int k = 0; k < 6; k++) begin
      logic [15:0] r;
      int guard;
      r = 16'($urandom());
      @(negedge clk);
      bus2.chal_valid = 1'b1;
      bus2.chal_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      guard = 0;
      while (bus2.chal_ready !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      total++;
      if (guard >= 20) begin bad++; $display("FAIL min_accept_wait rdy=%b want=1", bus2.chal_ready); end
      @(posedge clk);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        bus2.chal_valid = 1'b0;
        bus2.RESPONSE = (c == 3) ? r : 16'($urandom());
        total++;
        if (bus2.puf_reset !== (c == 0) || bus2.trigger !== (c >= 2) || bus2.resp_valid !== 1'b0) begin
          bad++; $display("FAIL min_wave c=%0d prst=%b trig=%b valid=%b", c, bus2.puf_reset, bus2.trigger, bus2.resp_valid);
        end
        @(posedge clk);
      end
      @(negedge clk);
      total++;
      if (bus2.resp_valid !== 1'b1 || bus2.resp_data !== r || bus2.resp_unstable !== 16'd0) begin
        bad++; $display("FAIL min_result valid=%b data=%h unst=%h want 1 %h 0000", bus2.resp_valid, bus2.resp_data, r, bus2.resp_unstable);
      end
      bus2.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus2.resp_ready = 1'b0;
    end
  endtask

  initial begin
    bus.chal_valid  = 1'b0;
    bus.chal_data   = '0;
    bus.RESPONSE    = '0;
    bus.resp_ready  = 1'b0;
    bus2.chal_valid = 1'b0;
    bus2.chal_data  = '0;
    bus2.RESPONSE   = '0;
    bus2.resp_ready = 1'b0;
    cur_chal = '0;
    exp_d = '0;
    exp_u = '0;
    test_reset();
    test_fixed_response();
    test_split_vote();
    test_random();
    test_back_to_back_hold();
    test_abort();
    test_min_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
